can_frame_tx: RTL and testbench
===============================

CAN_FRAME_TX -- requirements
Module: can_frame_tx

Interface
REQ-001 Parameter BIT_CLKS, default 200: CLK cycles per CAN bit; legal range 16..65535.
REQ-002 Parameter SAMPLE_PT, default 140: CLK count within a bit at which RX is sampled; legal range 1..BIT_CLKS-2.
REQ-003 Parameter IDLE_BITS, default 11: consecutive recessive RX bits required before SOF (bus integration).
REQ-004 Parameter IFS_BITS, default 3: intermission bits after EOF before tx_ready reasserts.
REQ-005 CLK  input  1  single clock; all logic on posedge CLK.
REQ-006 RST  input  1  reset, asynchronous, active-high.
REQ-007 RX  input  1  CAN bus receive level; 0 = dominant.
REQ-008 TX  output  1  open-drain bus drive; 0 = dominant, 'z = recessive; never drives 1.
REQ-009 tx_valid  input  1  frame request.
REQ-010 tx_ready  output  1  high only in IDLE; request accepted on tx_valid & tx_ready.
REQ-011 tx_id  input  11  standard identifier, MSB first.
REQ-012 tx_dlc  input  4  data length code.
REQ-013 tx_data  input  64  payload; byte0 = tx_data[63:56], each byte sent MSB first.
REQ-014 busy  output  1  high from accept until done.
REQ-015 done  output  1  one-cycle pulse at end of frame or abort.
REQ-016 ack_ok  output  1  dominant sampled in ACK slot; valid with done, held until next accept.
REQ-017 bit_err  output  1  bit-monitor mismatch outside arbitration and ACK slot; held as ack_ok.
REQ-018 arb_lost  output  1  recessive sent but dominant sampled within ID/RTR; held as ack_ok.

Function
REQ-019 Bit timer counts 0..BIT_CLKS-1 and wraps; TX updates only at count 0; RX is sampled only at count SAMPLE_PT.
REQ-020 On accept, tx_id, tx_dlc and tx_data are latched; input changes afterwards have no effect on the frame.
REQ-021 States: IDLE -> INTEGRATE -> STUFFED -> TAIL -> IFS -> IDLE; abort from INTEGRATE, STUFFED or TAIL goes directly to IDLE.
REQ-022 INTEGRATE: TX = 'z; on each dominant RX sample the recessive-bit counter clears; after IDLE_BITS consecutive recessive samples, the next bit boundary starts SOF.
REQ-023 STUFFED region bits, in order: SOF(0), ID[10:0], RTR(0), IDE(0), r0(0), DLC[3:0], N data bytes, CRC[14:0]; N = min(tx_dlc, 8); the DLC field carries tx_dlc unmodified.
REQ-024 CRC-15 polynomial is 0x4599 with init 0; it covers SOF through the last data bit, unstuffed bits only.
REQ-025 After 5 consecutive identical transmitted bits within the STUFFED region (stuff bits included in the run), one complement stuff bit is inserted; a stuff bit due after the last CRC bit is still sent.
REQ-026 TAIL, unstuffed: CRC delimiter (1), ACK slot (1), ACK delimiter (1), EOF 7x(1); all recessive.
REQ-027 ACK slot: ack_ok <= (RX sample == 0); a recessive sample there is not an error and the frame completes normally.
REQ-028 Bit monitor in ID/RTR: TX recessive & RX dominant -> arb_lost = 1, TX = 'z immediately, abort.
REQ-029 Bit monitor in all other STUFFED/TAIL bits except the ACK slot: any sample != sent -> bit_err = 1, abort.
REQ-030 Abort: TX = 'z from the next CLK, done pulses, IFS is skipped, tx_ready is high the following cycle.
REQ-031 Normal end: done pulses in the cycle the last EOF bit period ends; IFS then holds IFS_BITS recessive bits before IDLE.
REQ-032 A tx_valid held high while busy is ignored; it is accepted on the first IDLE cycle.

Reset
REQ-033 While RST = 1: state = IDLE, TX = 'z, tx_ready = 1, busy = 0, done = 0, ack_ok = 0, bit_err = 0, arb_lost = 0, timers and CRC = 0.
REQ-034 RST asserted mid-frame releases TX to 'z within the same cycle; no done pulse is generated.

Verification
REQ-035 RX = 1, accept ID 0x000 with DLC 0 -> SOF begins 11x200 clocks after accept; TX 'z for bit 5 (stuff) and dominant for bits 0-4.
REQ-036 ID 0x123, DLC 2, data 0xA55A; RX mirrors TX, with RX forced 0 in the ACK slot -> stuffed bit stream and CRC match the model; done pulses with ack_ok = 1, bit_err = 0.
REQ-037 Same frame with no ACK (RX stays 1 in the slot) -> done pulses with ack_ok = 0, bit_err = 0; EOF is complete.
REQ-038 Force RX = 0 while ID bit 3 is recessive -> arb_lost = 1; TX 'z from the next clock; done pulses; tx_ready = 1.
REQ-039 Force RX = 1 during a dominant data bit -> bit_err = 1; abort as in REQ-030.
REQ-040 tx_dlc = 15 -> 8 data bytes are sent and the DLC field reads 1111; RST pulsed mid-data -> TX = 'z and all outputs reach their reset values.

Source files
------------

// File: rtl/can_frame_tx_if.sv
// Frame request and status bundle between a CAN frame client and can_frame_tx.
interface can_frame_tx_if;
  logic        tx_valid;
  logic        tx_ready;
  logic [10:0] tx_id;
  logic [3:0]  tx_dlc;
  logic [63:0] tx_data;
  logic        busy;
  logic        done;
  logic        ack_ok;
  logic        bit_err;
  logic        arb_lost;

  modport master (
    output tx_valid, tx_id, tx_dlc, tx_data,
    input  tx_ready, busy, done, ack_ok, bit_err, arb_lost
  );

  modport slave (
    input  tx_valid, tx_id, tx_dlc, tx_data,
    output tx_ready, busy, done, ack_ok, bit_err, arb_lost
  );
endinterface

// File: rtl/can_frame_tx.sv
// CAN 2.0A base-frame transmitter: bus integration, bit stuffing, CRC-15, ACK check,
// arbitration and bit monitoring on an open-drain TX line.
module can_frame_tx #(
  parameter int unsigned BIT_CLKS  = 200,
  parameter int unsigned SAMPLE_PT = 140,
  parameter int unsigned IDLE_BITS = 11,
  parameter int unsigned IFS_BITS  = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          RX,
  output wire           TX,
  can_frame_tx_if.slave bus
);

  localparam logic [15:0] CntMax   = 16'(BIT_CLKS - 1);
  localparam logic [15:0] SampleAt = 16'(SAMPLE_PT);
  localparam logic [15:0] IdleBits = 16'(IDLE_BITS);
  localparam logic [15:0] IfsLast  = 16'(IFS_BITS - 1);

  typedef enum logic [2:0] {StIdle, StIntegrate, StStuffed, StTail, StIfs} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [82:0] sh_q, sh_d;            // SOF..DLC header followed by payload, MSB first
  logic [6:0]  data_end_q, data_end_d;
  logic [6:0]  pos_q, pos_d;          // unstuffed bits already sent
  logic [14:0] crc_q, crc_d;
  logic [2:0]  run_q, run_d;
  logic        last_q, last_d;
  logic        cur_q, cur_d;          // bit on the bus, 1 = recessive
  logic        arb_q, arb_d;
  logic [3:0]  tail_q, tail_d;
  logic [15:0] bitcnt_q, bitcnt_d;
  logic        ack_q, ack_d;
  logic        berr_q, berr_d;
  logic        lost_q, lost_d;
  logic        done_q, done_d;

  logic        cnt_wrap, sample_en, send_next, abort, nb, fb;
  logic [3:0]  n_bytes;
  logic [6:0]  crc_end;

  assign cnt_wrap  = (cnt_q == CntMax);
  assign sample_en = (cnt_q == SampleAt);
  assign crc_end   = data_end_q + 7'd15;
  assign n_bytes   = bus.tx_dlc[3] ? 4'd8 : bus.tx_dlc;

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    data_end_d = data_end_q;
    pos_d      = pos_q;
    crc_d      = crc_q;
    run_d      = run_q;
    last_d     = last_q;
    cur_d      = cur_q;
    arb_d      = arb_q;
    tail_d     = tail_q;
    bitcnt_d   = bitcnt_q;
    ack_d      = ack_q;
    berr_d     = berr_q;
    lost_d     = lost_q;
    done_d     = 1'b0;
    send_next  = 1'b0;
    abort      = 1'b0;
    nb         = 1'b1;
    fb         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.tx_valid) begin
          state_d    = StIntegrate;
          sh_d       = {1'b0, bus.tx_id, 3'b000, bus.tx_dlc, bus.tx_data};
          data_end_d = 7'd19 + {n_bytes, 3'b000};
          pos_d      = '0;
          crc_d      = '0;
          run_d      = '0;
          last_d     = 1'b1;
          cur_d      = 1'b1;
          arb_d      = 1'b0;
          bitcnt_d   = '0;
          ack_d      = 1'b0;
          berr_d     = 1'b0;
          lost_d     = 1'b0;
        end
      end
      StIntegrate: begin
        if (sample_en) begin
          if (!RX) bitcnt_d = '0;
          else if (bitcnt_q != IdleBits) bitcnt_d = bitcnt_q + 16'd1;
        end
        if (cnt_wrap && bitcnt_q == IdleBits) begin
          state_d   = StStuffed;
          send_next = 1'b1;
        end
      end
      StStuffed: begin
        if (sample_en) begin
          if (arb_q) begin
            if (cur_q && !RX) begin
              lost_d = 1'b1;
              abort  = 1'b1;
            end
          end else if (RX != cur_q) begin
            berr_d = 1'b1;
            abort  = 1'b1;
          end
        end
        if (cnt_wrap) begin
          if (run_q == 3'd5) begin
            cur_d  = ~last_q;
            last_d = ~last_q;
            run_d  = 3'd1;
          end else if (pos_q == crc_end) begin
            state_d = StTail;
            cur_d   = 1'b1;
            arb_d   = 1'b0;
            tail_d  = '0;
          end else begin
            send_next = 1'b1;
          end
        end
      end
      StTail: begin
        if (sample_en) begin
          if (tail_q == 4'd1) begin
            ack_d = ~RX;
          end else if (!RX) begin
            berr_d = 1'b1;
            abort  = 1'b1;
          end
        end
        if (cnt_wrap) begin
          if (tail_q == 4'd9) begin
            state_d  = StIfs;
            done_d   = 1'b1;
            bitcnt_d = '0;
          end else begin
            tail_d = tail_q + 4'd1;
          end
        end
      end
      StIfs: begin
        if (cnt_wrap) begin
          if (bitcnt_q == IfsLast) state_d = StIdle;
          else bitcnt_d = bitcnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (send_next) begin
      if (pos_q < data_end_q) begin
        nb    = sh_q[82];
        sh_d  = {sh_q[81:0], 1'b0};
        fb    = nb ^ crc_q[14];
        crc_d = {crc_q[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
      end else begin
        nb    = crc_q[14];
        crc_d = {crc_q[13:0], 1'b0};
      end
      cur_d  = nb;
      last_d = nb;
      run_d  = (nb == last_q) ? run_q + 3'd1 : 3'd1;
      pos_d  = pos_q + 7'd1;
      arb_d  = (pos_q >= 7'd1) && (pos_q <= 7'd12);
    end

    if (abort) begin
      state_d = StIdle;
      cur_d   = 1'b1;
      done_d  = 1'b1;
    end

    cnt_d = (state_q == StIdle || state_d == StIdle || cnt_wrap) ? '0 : cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      sh_q       <= '0;
      data_end_q <= '0;
      pos_q      <= '0;
      crc_q      <= '0;
      run_q      <= '0;
      last_q     <= 1'b1;
      cur_q      <= 1'b1;
      arb_q      <= 1'b0;
      tail_q     <= '0;
      bitcnt_q   <= '0;
      ack_q      <= 1'b0;
      berr_q     <= 1'b0;
      lost_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      data_end_q <= data_end_d;
      pos_q      <= pos_d;
      crc_q      <= crc_d;
      run_q      <= run_d;
      last_q     <= last_d;
      cur_q      <= cur_d;
      arb_q      <= arb_d;
      tail_q     <= tail_d;
      bitcnt_q   <= bitcnt_d;
      ack_q      <= ack_d;
      berr_q     <= berr_d;
      lost_q     <= lost_d;
      done_q     <= done_d;
    end
  end

  // Open drain: only ever pull the bus low.
  assign TX = cur_q ? 1'bz : 1'b0;

  assign bus.tx_ready = (state_q == StIdle);
  assign bus.busy     = (state_q == StIntegrate) || (state_q == StStuffed) ||
                        (state_q == StTail);
  assign bus.done     = done_q;
  assign bus.ack_ok   = ack_q;
  assign bus.bit_err  = berr_q;
  assign bus.arb_lost = lost_q;

endmodule

// File: tb/tb_can_frame_tx.sv
// Bench for can_frame_tx: frames built from field rules, CRC by polynomial division,
// stuffing by run counting; every transmitted bit compared against that stream.
module tb_can_frame_tx;
  localparam int unsigned BC   = 20;
  localparam int unsigned SP   = 13;
  localparam int unsigned IB   = 11;
  localparam int unsigned IFSB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_ovr_en = 1'b0;
  logic rx_ovr_val = 1'b1;
  wire  tx_w;
  wire  rx_w;

  pullup (tx_w);
  assign rx_w = rx_ovr_en ? rx_ovr_val : tx_w;

  can_frame_tx_if bus();

  can_frame_tx #(
    .BIT_CLKS (BC),
    .SAMPLE_PT(SP),
    .IDLE_BITS(IB),
    .IFS_BITS (IFSB)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .RX (rx_w),
    .TX (tx_w),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_bits[$];
  int exp_pos[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: field list, CRC as remainder of M(x)*x^15 mod G(x), then stuffing.
  function automatic void build(input logic [10:0] id, input logic [3:0] dlc,
                                input logic [63:0] data);
    int ub[$];
    int m[$];
    int n, len, last, run;
    logic [15:0] g;
    g = 16'hC599;
    ub.push_back(0);
    for (int i = 10; i >= 0; i--) ub.push_back(int'(id[i]));
    for (int i = 0; i < 3; i++) ub.push_back(0);
    for (int i = 3; i >= 0; i--) ub.push_back(int'(dlc[i]));
    n = (dlc > 4'd8) ? 8 : int'(dlc);
    for (int i = 0; i < 8 * n; i++) ub.push_back(int'(data[63-i]));
    len = ub.size();
    m = ub;
    for (int i = 0; i < 15; i++) m.push_back(0);
    for (int i = 0; i < len; i++)
      if (m[i] == 1)
        for (int j = 0; j < 16; j++) m[i+j] = m[i+j] ^ int'(g[15-j]);
    for (int i = 0; i < 15; i++) ub.push_back(m[len+i]);
    exp_bits.delete();
    exp_pos.delete();
    last = -1;
    run = 0;
    for (int i = 0; i < ub.size(); i++) begin
      exp_bits.push_back(ub[i]);
      exp_pos.push_back(i);
      if (ub[i] == last) run++;
      else begin
        run = 1;
        last = ub[i];
      end
      if (run == 5) begin
        exp_bits.push_back(1 - last);
        exp_pos.push_back(-1);
        last = 1 - last;
        run = 1;
      end
    end
  endfunction

  // mode: 0 acked, 1 no ack, 2 arbitration loss, 3 bit error, 4 reset at tgt bit
  task automatic run_frame(input logic [10:0] id, input logic [3:0] dlc,
                           input logic [63:0] data, input int mode, input int tgt,
                           input bit hold_valid);
    build(id, dlc, data);
    rx_ovr_en = 1'b0;
    @(negedge clk);
    chk("ready_before_accept", bus.tx_ready, 1);
    bus.tx_valid = 1'b1;
    bus.tx_id    = id;
    bus.tx_dlc   = dlc;
    bus.tx_data  = data;
    @(posedge clk);
    #1;
    if (!hold_valid) bus.tx_valid = 1'b0;
    bus.tx_id   = 11'($urandom);
    bus.tx_dlc  = 4'($urandom);
    bus.tx_data = {$urandom, $urandom};
    chk("busy_after_accept", bus.busy, 1);
    chk("ready_after_accept", bus.tx_ready, 0);
    repeat (IB * BC - 1) @(posedge clk);
    #1;
    chk("tx_idle_before_sof", tx_w, 1);
    @(posedge clk);
    #1;
    chk("sof_start", tx_w, 0);
    for (int k = 0; k < exp_bits.size(); k++) begin
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("stuffed_bit%0d", k), tx_w, 64'(exp_bits[k]));
      if (mode >= 2 && exp_pos[k] == tgt) begin
        if (mode == 4) begin
          #1 rst = 1'b1;
          #1;
          chk("rst_tx_released", tx_w, 1);
          chk("rst_ready", bus.tx_ready, 1);
          chk("rst_busy", bus.busy, 0);
          chk("rst_flags", {bus.done, bus.ack_ok, bus.bit_err, bus.arb_lost}, 0);
          repeat (3) @(posedge clk);
          #1;
          chk("rst_no_done", bus.done, 0);
          chk("rst_tx_held", tx_w, 1);
          @(negedge clk);
          rst = 1'b0;
          return;
        end
        rx_ovr_en  = 1'b1;
        rx_ovr_val = (mode == 2) ? 1'b0 : 1'b1;
        repeat (SP - 2) @(posedge clk);
        #1;
        chk("abort_no_early_done", bus.done, 0);
        if (mode == 3) chk("tx_dominant_before_sample", tx_w, 0);
        @(posedge clk);
        #1;
        chk("abort_done", bus.done, 1);
        chk("abort_tx_released", tx_w, 1);
        chk("abort_ready", bus.tx_ready, 1);
        chk("abort_busy", bus.busy, 0);
        chk("abort_arb_lost", bus.arb_lost, (mode == 2) ? 1 : 0);
        chk("abort_bit_err", bus.bit_err, (mode == 3) ? 1 : 0);
        rx_ovr_en = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_done_pulse", bus.done, 0);
        chk("abort_flags_held", {bus.arb_lost, bus.bit_err}, (mode == 2) ? 2 : 1);
        return;
      end
      repeat (BC - 2) @(posedge clk);
      #1;
    end
    for (int t = 0; t < 10; t++) begin
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("tail_bit%0d", t), tx_w, 1);
      chk("no_done_in_tail", bus.done, 0);
      rx_ovr_en  = (t == 1 && mode == 0);
      rx_ovr_val = 1'b0;
      repeat (BC - 2) @(posedge clk);
      #1;
    end
    chk("eof_done", bus.done, 1);
    chk("eof_ack_ok", bus.ack_ok, (mode == 0) ? 1 : 0);
    chk("eof_bit_err", bus.bit_err, 0);
    chk("eof_arb_lost", bus.arb_lost, 0);
    chk("eof_busy", bus.busy, 0);
    chk("ifs_not_ready", bus.tx_ready, 0);
    @(posedge clk);
    #1;
    chk("done_pulse", bus.done, 0);
    chk("ack_ok_held", bus.ack_ok, (mode == 0) ? 1 : 0);
    repeat (IFSB * BC - 2) @(posedge clk);
    #1;
    chk("ifs_end_not_ready", bus.tx_ready, 0);
    @(posedge clk);
    #1;
    chk("ifs_ready", bus.tx_ready, 1);
    if (hold_valid) begin
      @(posedge clk);
      #1;
      chk("held_valid_accept", bus.busy, 1);
      bus.tx_valid = 1'b0;
    end
  endtask

  initial begin
    logic [10:0] rid;
    logic [3:0]  rdlc;
    logic [63:0] rdata;
    bus.tx_valid = 1'b0;
    bus.tx_id    = '0;
    bus.tx_dlc   = '0;
    bus.tx_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", tx_w, 1);
    chk("reset_ready", bus.tx_ready, 1);
    chk("reset_busy", bus.busy, 0);
    chk("reset_flags", {bus.done, bus.ack_ok, bus.bit_err, bus.arb_lost}, 0);
    @(negedge clk);
    rst = 1'b0;

    run_frame(11'h000, 4'd0, 64'h0, 0, -1, 1'b0);
    run_frame(11'h123, 4'd2, {16'hA55A, 48'h0}, 0, -1, 1'b0);
    run_frame(11'h123, 4'd2, {16'hA55A, 48'h0}, 1, -1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      rid   = 11'($urandom);
      rdlc  = 4'($urandom_range(0, 8));
      rdata = {$urandom, $urandom};
      run_frame(rid, rdlc, rdata, i % 2, -1, 1'b0);
    end
    rid = 11'($urandom) | 11'h008;
    run_frame(rid, 4'($urandom_range(0, 8)), {$urandom, $urandom}, 2, 8, 1'b0);
    rdata = {$urandom, $urandom};
    rdata[63] = 1'b0;
    run_frame(11'($urandom), 4'($urandom_range(1, 8)), rdata, 3, 19, 1'b0);
    run_frame(11'($urandom), 4'd15, {$urandom, $urandom}, 0, -1, 1'b0);
    rdata = {$urandom, $urandom};
    rdata[63] = 1'b0;
    run_frame(11'($urandom), 4'd15, rdata, 4, 19, 1'b0);
    run_frame(11'($urandom), 4'($urandom_range(0, 8)), {$urandom, $urandom}, 0, -1, 1'b1);

    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("final_rst_tx", tx_w, 1);
    chk("final_rst_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
